// File: rtl/ghost_motion_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_motion_unit_pkg
//  Description : Shared playfield geometry, direction codes and state encoding
//                used by the ghost motion unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ghost_motion_unit_pkg;

    // Playfield geometry and direction codes, same values as the shared defines
    localparam int WIDTH        = 640;
    localparam int HEIGHT       = 480;
    localparam int TILE_COL_NUM = 32;
    localparam int TILE_ROW_NUM = 24;

    localparam int X_W       = $clog2(WIDTH);
    localparam int Y_W       = $clog2(HEIGHT);
    localparam int WALL_BITS = TILE_ROW_NUM * TILE_COL_NUM;
    localparam int TIDX_W    = 8;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_MOVE   = 2'd2,
        ST_ARRIVE = 2'd3
    } gm_state_e;

    // Signed so that a step off the left/top edge is representable as -1
    typedef logic signed [TIDX_W-1:0] tile_idx_t;

    function automatic tile_idx_t tile_of(input int px, input int tile);
        return tile_idx_t'(px / tile);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_motion_unit_wall_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_wall_lookup
//  Description : Registered wall-bit select at a target tile plus a flag for
//                targets outside the legal box.
//  Revision    : 1.0 - initial release
// ============================================================================
module ghost_wall_lookup
    import ghost_motion_unit_pkg::*;
#(
    parameter int COL_MIN = 0,
    parameter int COL_MAX = TILE_COL_NUM - 1,
    parameter int ROW_MIN = 0,
    parameter int ROW_MAX = TILE_ROW_NUM - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  tile_idx_t            tgt_col,
    input  tile_idx_t            tgt_row,
    input  logic [WALL_BITS-1:0] tilemap_walls,
    output logic                 wall_hit,
    output logic                 out_of_bounds
);

    localparam int IDX_W = $clog2(WALL_BITS);

    // The legal box is also clipped to the map so the bit select never runs off
    localparam tile_idx_t LO_COL = tile_idx_t'((COL_MIN < 0) ? 0 : COL_MIN);
    localparam tile_idx_t HI_COL = tile_idx_t'((COL_MAX > TILE_COL_NUM - 1) ? TILE_COL_NUM - 1 : COL_MAX);
    localparam tile_idx_t LO_ROW = tile_idx_t'((ROW_MIN < 0) ? 0 : ROW_MIN);
    localparam tile_idx_t HI_ROW = tile_idx_t'((ROW_MAX > TILE_ROW_NUM - 1) ? TILE_ROW_NUM - 1 : ROW_MAX);

    logic             wall_q, wall_d;
    logic             oob_q, oob_d;
    logic             in_box;
    logic [IDX_W-1:0] bit_idx;

    always_comb begin
        wall_d  = wall_q;
        oob_d   = oob_q;
        in_box  = (tgt_col >= LO_COL) && (tgt_col <= HI_COL) &&
                  (tgt_row >= LO_ROW) && (tgt_row <= HI_ROW);
        bit_idx = '0;
        if (in_box) begin
            bit_idx = IDX_W'(int'(tgt_row) * TILE_COL_NUM + int'(tgt_col));
        end
        if (sample_en) begin
            oob_d  = !in_box;
            wall_d = in_box && tilemap_walls[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wall_q <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            wall_q <= wall_d;
            oob_q  <= oob_d;
        end
    end

    assign wall_hit      = wall_q;
    assign out_of_bounds = oob_q;

endmodule
`default_nettype wire

// File: rtl/ghost_motion_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_motion_unit
//  Description : Validates a ghost's requested next tile against walls and the
//                playfield box, then walks the sprite there on move ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module ghost_motion_unit
    import ghost_motion_unit_pkg::*;
#(
    parameter int TILE_SIZE = 20,
    parameter int STEP_PX   = 4,
    parameter int START_X   = 600,
    parameter int START_Y   = 320,
    parameter int BOUND_X0  = 0,
    parameter int BOUND_X1  = 620,
    parameter int BOUND_Y0  = 0,
    parameter int BOUND_Y1  = 460
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 move_tick,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [X_W-1:0]       req_x,
    input  logic [Y_W-1:0]       req_y,
    input  logic [1:0]           req_dir,
    input  logic [WALL_BITS-1:0] tilemap_walls,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [X_W-1:0]       pix_x,
    output logic [Y_W-1:0]       pix_y,
    output logic [1:0]           direction,
    output logic                 arrive,
    output logic                 blocked
);

    localparam int STEPS = TILE_SIZE / STEP_PX;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [X_W-1:0]        STEP_XV   = X_W'(STEP_PX);
    localparam logic [Y_W-1:0]        STEP_YV   = Y_W'(STEP_PX);
    localparam logic signed [X_W:0]   DX_TILE   = (X_W + 1)'(TILE_SIZE);
    localparam logic signed [Y_W:0]   DY_TILE   = (Y_W + 1)'(TILE_SIZE);
    localparam logic [X_W-1:0]        START_XV  = X_W'(START_X);
    localparam logic [Y_W-1:0]        START_YV  = Y_W'(START_Y);
    localparam tile_idx_t             START_COL = tile_of(START_X, TILE_SIZE);
    localparam tile_idx_t             START_ROW = tile_of(START_Y, TILE_SIZE);
    localparam tile_idx_t             ONE       = tile_idx_t'(1);
    localparam tile_idx_t             ZERO      = tile_idx_t'(0);

    gm_state_e        state_q, state_d;
    logic             phase_q, phase_d;
    logic [X_W-1:0]   x_q, x_d, pix_x_q, pix_x_d, req_x_q, req_x_d;
    logic [Y_W-1:0]   y_q, y_d, pix_y_q, pix_y_d, req_y_q, req_y_d;
    logic [1:0]       dir_q, dir_d, mv_dir_q, mv_dir_d, req_dir_q, req_dir_d;
    tile_idx_t        col_q, col_d, row_q, row_d;
    tile_idx_t        tgt_col_q, tgt_col_d, tgt_row_q, tgt_row_d;
    logic             legal_q, legal_d;
    logic [CNT_W-1:0] step_q, step_d;

    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic                dx_pos, dx_neg, dx_zero, dy_pos, dy_neg, dy_zero;
    logic                legal_w;
    logic [1:0]          dir_w;
    tile_idx_t           tgt_col_w, tgt_row_w;
    logic                sample_en, wall_hit, out_of_bounds, reject;

    // Movement follows the deltas; the controller's hint is only captured
    logic unused_req_dir;
    assign unused_req_dir = ^req_dir_q;

    always_comb begin
        dx        = $signed({1'b0, req_x_q}) - $signed({1'b0, x_q});
        dy        = $signed({1'b0, req_y_q}) - $signed({1'b0, y_q});
        dx_pos    = (dx == DX_TILE);
        dx_neg    = (dx == -DX_TILE);
        dx_zero   = (dx == '0);
        dy_pos    = (dy == DY_TILE);
        dy_neg    = (dy == -DY_TILE);
        dy_zero   = (dy == '0);
        legal_w   = ((dx_pos || dx_neg) && dy_zero) || ((dy_pos || dy_neg) && dx_zero);
        dir_w     = DIR_DOWN;
        if (dx_pos)      dir_w = DIR_RIGHT;
        else if (dx_neg) dir_w = DIR_LEFT;
        else if (dy_neg) dir_w = DIR_UP;
        tgt_col_w = col_q + (dx_pos ? ONE : (dx_neg ? -ONE : ZERO));
        tgt_row_w = row_q + (dy_pos ? ONE : (dy_neg ? -ONE : ZERO));
    end

    assign sample_en = (state_q == ST_CHECK) && !phase_q;

    ghost_wall_lookup #(
        .COL_MIN (BOUND_X0 / TILE_SIZE),
        .COL_MAX (BOUND_X1 / TILE_SIZE),
        .ROW_MIN (BOUND_Y0 / TILE_SIZE),
        .ROW_MAX (BOUND_Y1 / TILE_SIZE)
    ) u_wall_lookup (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .tgt_col       (tgt_col_w),
        .tgt_row       (tgt_row_w),
        .tilemap_walls (tilemap_walls),
        .wall_hit      (wall_hit),
        .out_of_bounds (out_of_bounds)
    );

    assign reject = !legal_q || wall_hit || out_of_bounds;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        req_x_d   = req_x_q;
        req_y_d   = req_y_q;
        req_dir_d = req_dir_q;
        dir_d     = dir_q;
        mv_dir_d  = mv_dir_q;
        col_d     = col_q;
        row_d     = row_q;
        tgt_col_d = tgt_col_q;
        tgt_row_d = tgt_row_q;
        legal_d   = legal_q;
        step_d    = step_q;
        req_ready = 1'b0;
        arrive    = 1'b0;
        blocked   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_x_d   = req_x;
                    req_y_d   = req_y;
                    req_dir_d = req_dir;
                    phase_d   = 1'b0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // First cycle classifies and samples the wall; second decides
                if (!phase_q) begin
                    legal_d   = legal_w;
                    mv_dir_d  = dir_w;
                    tgt_col_d = tgt_col_w;
                    tgt_row_d = tgt_row_w;
                    phase_d   = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (reject) begin
                        blocked = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        dir_d   = mv_dir_q;
                        step_d  = '0;
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (move_tick) begin
                    case (mv_dir_q)
                        DIR_UP:   pix_y_d = pix_y_q - STEP_YV;
                        DIR_DOWN: pix_y_d = pix_y_q + STEP_YV;
                        DIR_LEFT: pix_x_d = pix_x_q - STEP_XV;
                        default:  pix_x_d = pix_x_q + STEP_XV;
                    endcase
                    step_d = step_q + CNT_W'(1);
                    // Commit on the final tick so x/y change together with arrive
                    if (step_q == LAST_STEP) begin
                        x_d     = req_x_q;
                        y_d     = req_y_q;
                        col_d   = tgt_col_q;
                        row_d   = tgt_row_q;
                        state_d = ST_ARRIVE;
                    end
                end
            end
            ST_ARRIVE: begin
                arrive  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= 1'b0;
            x_q       <= START_XV;
            y_q       <= START_YV;
            pix_x_q   <= START_XV;
            pix_y_q   <= START_YV;
            req_x_q   <= START_XV;
            req_y_q   <= START_YV;
            req_dir_q <= DIR_DOWN;
            dir_q     <= DIR_DOWN;
            mv_dir_q  <= DIR_DOWN;
            col_q     <= START_COL;
            row_q     <= START_ROW;
            tgt_col_q <= START_COL;
            tgt_row_q <= START_ROW;
            legal_q   <= 1'b0;
            step_q    <= '0;
        end else begin
            phase_q   <= phase_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            req_x_q   <= req_x_d;
            req_y_q   <= req_y_d;
            req_dir_q <= req_dir_d;
            dir_q     <= dir_d;
            mv_dir_q  <= mv_dir_d;
            col_q     <= col_d;
            row_q     <= row_d;
            tgt_col_q <= tgt_col_d;
            tgt_row_q <= tgt_row_d;
            legal_q   <= legal_d;
            step_q    <= step_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign direction = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_ghost_motion_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghost_motion_unit
//  Description : Scoreboard bench for ghost_motion_unit with directed moves.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_motion_unit;
    import ghost_motion_unit_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 move_tick;
    logic                 req_valid;
    logic                 req_ready;
    logic [X_W-1:0]       req_x;
    logic [Y_W-1:0]       req_y;
    logic [1:0]           req_dir;
    logic [WALL_BITS-1:0] tilemap_walls;
    logic [X_W-1:0]       x, pix_x;
    logic [Y_W-1:0]       y, pix_y;
    logic [1:0]           direction;
    logic                 arrive, blocked;

    ghost_motion_unit dut (
        .clk           (clk),
        .reset         (reset),
        .move_tick     (move_tick),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_dir       (req_dir),
        .tilemap_walls (tilemap_walls),
        .x             (x),
        .y             (y),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .direction     (direction),
        .arrive        (arrive),
        .blocked       (blocked)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_block; int x; int y; int dir; int cyc; } ev_t;
    typedef struct { int px; int py; } pix_t;

    ev_t  ev_q[$];
    pix_t pix_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cur_x = 600;
    int   cur_y = 320;
    int   cur_dir = DIR_DOWN;
    bit   tick_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe every other cycle while enabled
    initial begin
        move_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            move_tick = tick_en ? ~move_tick : 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT reports an event or a pixel step
    initial begin
        ev_t  e;
        pix_t p;
        int   prev_px;
        int   prev_py;
        prev_px = 600;
        prev_py = 320;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (arrive || blocked) begin
                    if (ev_q.size() == 0) begin
                        chk("unexpected_event", {arrive, blocked}, 0);
                    end else begin
                        e = ev_q.pop_front();
                        chk("ev_blocked", blocked, e.is_block);
                        chk("ev_arrive", arrive, !e.is_block);
                        chk("ev_x", x, e.x);
                        chk("ev_y", y, e.y);
                        chk("ev_pix_x", pix_x, e.x);
                        chk("ev_pix_y", pix_y, e.y);
                        chk("ev_direction", direction, e.dir);
                        if (e.cyc >= 0) chk("blocked_cycle", cyc, e.cyc);
                    end
                end
                if (pix_x != prev_px || pix_y != prev_py) begin
                    if (pix_q.size() == 0) begin
                        chk("unexpected_pix_step", pix_y, prev_py);
                    end else begin
                        p = pix_q.pop_front();
                        chk("step_pix_x", pix_x, p.px);
                        chk("step_pix_y", pix_y, p.py);
                    end
                end
            end
            prev_px = pix_x;
            prev_py = pix_y;
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk(name, 0, 1);
    endtask

    task automatic handshake(input int rx, input int ry, input int rdir, output int hs);
        wait_ready("ready_timeout");
        req_x     = X_W'(rx);
        req_y     = Y_W'(ry);
        req_dir   = 2'(rdir);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        hs        = cyc;
        req_valid = 1'b0;
        chk("ready_low_after_hs", req_ready, 0);
    endtask

    task automatic expect_block(input int rx, input int ry);
        int hs;
        handshake(rx, ry, DIR_DOWN, hs);
        ev_q.push_back('{1'b1, cur_x, cur_y, cur_dir, hs + 1});
        wait_ready("blocked_return_timeout");
    endtask

    task automatic expect_move(input int rx, input int ry, input int edir, input bit poke);
        int   hs;
        int   sx;
        int   sy;
        pix_t p;
        handshake(rx, ry, edir, hs);
        sx = (rx - cur_x) / 5;
        sy = (ry - cur_y) / 5;
        for (int i = 1; i <= 5; i++) begin
            p.px = cur_x + sx * i;
            p.py = cur_y + sy * i;
            pix_q.push_back(p);
        end
        ev_q.push_back('{1'b0, rx, ry, edir, -1});
        if (poke) begin
            repeat (4) @(negedge clk);
            chk("ready_in_move", req_ready, 0);
            // New request and a wall on the target mid-move must both be ignored
            tilemap_walls[(ry / 20) * TILE_COL_NUM + (rx / 20)] = 1'b1;
            req_x     = X_W'(620);
            req_y     = Y_W'(320);
            req_valid = 1'b1;
            repeat (2) @(negedge clk);
            req_valid = 1'b0;
        end
        cur_x   = rx;
        cur_y   = ry;
        cur_dir = edir;
        wait_ready("move_timeout");
        tilemap_walls = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int n;
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_x         = '0;
        req_y         = '0;
        req_dir       = '0;
        tilemap_walls = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", x, 600);
        chk("rst_y", y, 320);
        chk("rst_pix_x", pix_x, 600);
        chk("rst_pix_y", pix_y, 320);
        chk("rst_direction", direction, DIR_DOWN);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arrive", arrive, 0);
        chk("rst_blocked", blocked, 0);
        reset   = 1'b1;
        tick_en = 1'b1;
        @(negedge clk);

        // Wall on row 17 col 30 rejects the step down
        tilemap_walls[17 * TILE_COL_NUM + 30] = 1'b1;
        expect_block(600, 340);
        tilemap_walls = '0;
        expect_block(620, 340);
        expect_block(600, 320);

        // Walls on the current tile and a neighbour must not block
        tilemap_walls[16 * TILE_COL_NUM + 30] = 1'b1;
        tilemap_walls[17 * TILE_COL_NUM + 31] = 1'b1;
        expect_move(600, 340, DIR_DOWN, 1'b1);
        expect_move(620, 340, DIR_RIGHT, 1'b0);
        expect_move(600, 340, DIR_LEFT, 1'b0);
        expect_move(600, 320, DIR_UP, 1'b0);

        // Reset after two ticks of an upward move
        handshake(600, 300, DIR_UP, hs);
        pix_q.push_back('{600, 316});
        pix_q.push_back('{600, 312});
        n = 0;
        while (pix_y != 312 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_move_reach_312", pix_y, 312);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pix_y", pix_y, 320);
        chk("mid_rst_pix_x", pix_x, 600);
        chk("mid_rst_y", y, 320);
        chk("mid_rst_direction", direction, DIR_DOWN);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_arrive", arrive, 0);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        cur_dir = DIR_DOWN;
        chk("mid_rst_pix_queue", pix_q.size(), 0);

        // Walk to the top-left corner, then probe both wrap-around requests
        for (int i = 0; i < 30; i++) expect_move(cur_x - 20, cur_y, DIR_LEFT, 1'b0);
        for (int i = 0; i < 16; i++) expect_move(cur_x, cur_y - 20, DIR_UP, 1'b0);
        expect_block(1004, 0);
        expect_block(0, 492);
        expect_move(20, 0, DIR_RIGHT, 1'b0);

        repeat (10) @(negedge clk);
        chk("final_x", x, 20);
        chk("final_y", y, 0);
        chk("ev_queue_empty", ev_q.size(), 0);
        chk("pix_queue_empty", pix_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ghost_motion_unit.md
# ghost_motion_unit

Consumer side of the ghost controller interface: accepts the controller's requested next tile position, checks it against the wall map and playfield boundary, then moves the ghost sprite there pixel-by-pixel on move ticks. It returns the committed tile-aligned position to the controller, which uses it as its current `x`/`y`. There is one instance per ghost, located between that ghost's controller and the sprite renderer and collision logic.

## Interface
- `TILE_SIZE`, 20, tile pitch in pixels.
- `STEP_PX`, 4, pixels advanced per move tick; must divide `TILE_SIZE`.
- `START_X`, 600, reset pixel x; multiple of `TILE_SIZE`.
- `START_Y`, 320, reset pixel y; multiple of `TILE_SIZE`.
- `BOUND_X0`, 0, leftmost legal tile origin x.
- `BOUND_X1`, 620, rightmost legal tile origin x.
- `BOUND_Y0`, 0, topmost legal tile origin y.
- `BOUND_Y1`, 460, bottommost legal tile origin y.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `move_tick`  in  1  one-cycle strobe that advances the sprite.
- `req_valid`  in  1  controller presents `req_x`/`req_y`/`req_dir`.
- `req_ready`  out  1  high only in IDLE.
- `req_x`  in  $clog2(`WIDTH)  requested tile origin x.
- `req_y`  in  $clog2(`HEIGHT)  requested tile origin y.
- `req_dir`  in  2  controller's direction code (`dir_*`).
- `tilemap_walls`  in  `tile_row_num*`tile_col_num  wall bitmap; bit index is row*`tile_col_num+col; 1 means wall.
- `x`  out  $clog2(`WIDTH)  committed tile origin x, fed back to the controller.
- `y`  out  $clog2(`HEIGHT)  committed tile origin y.
- `pix_x`  out  $clog2(`WIDTH)  sprite render x.
- `pix_y`  out  $clog2(`HEIGHT)  sprite render y.
- `direction`  out  2  direction of the last accepted move.
- `arrive`  out  1  one-cycle pulse when a move completes.
- `blocked`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Reset values:
  - `x` = `pix_x` = `START_X`; `y` = `pix_y` = `START_Y`.
  - `direction` = `dir_down`.
  - `arrive` = `blocked` = 0.
  - State is IDLE, so `req_ready` = 1.
  - The internal tile column/row counters are set to `START_X`/`TILE_SIZE` and `START_Y`/`TILE_SIZE`, computed at elaboration. There is no runtime divider.
- IDLE: when `req_valid` and `req_ready` are both high, capture the request and go to CHECK.
- CHECK classifies the request from the deltas `req_x - x` and `req_y - y`:
  - The move is legal only if exactly one axis changes by ±`TILE_SIZE` and the other is 0.
  - Derive the move direction from the delta. `req_dir` is recorded but does not override the delta.
  - Target tile = current tile col/row ±1 on the moving axis.
  - Reject if the target lies outside the `BOUND_*` box, if the delta is illegal (including zero or diagonal), or if the wall bit is set.
  - On reject: pulse `blocked`, leave `x`/`y`/`pix_*`/`direction` unchanged, return to IDLE.
  - On accept: `direction` takes the derived direction; go to MOVE.
- MOVE: on each cycle with `move_tick` high, add or subtract `STEP_PX` on the moving axis of `pix_x`/`pix_y`. After `TILE_SIZE`/`STEP_PX` ticks, `pix` equals the target; go to ARRIVE.
- ARRIVE:
  - `x`/`y` take the target values.
  - The tile counters are updated.
  - `arrive` pulses.
  - Return to IDLE.
- Arithmetic: all pixel math uses the full port widths. The deltas are computed one bit wider and signed. Boundary checks are done on tile indices.

## Timing
- Handshake fires in cycle N.
- CHECK in N+1: the wall bit is looked up and registered.
- Decision in N+2: either the `blocked` pulse (with `req_ready` high again in N+3), or entry to MOVE.
- `move_tick` is ignored in IDLE/CHECK/ARRIVE.
- `move_tick` in the same cycle as MOVE entry is not counted.
- Total latency for an accepted move: 2 cycles + `TILE_SIZE`/`STEP_PX` ticks + 1 cycle. `arrive` is high in the cycle `x`/`y` update.
- `req_valid` while `req_ready` = 0 is ignored. Nothing is queued, and the controller must hold or re-present the request.
- `tilemap_walls` is sampled only in CHECK. Changes during MOVE do not abort the move.
- An asynchronous reset mid-move immediately restores the start position, `dir_down`, and IDLE. No `arrive` pulse is generated.

## Structure
- Shared `define.v` holds `WIDTH`, `HEIGHT`, `tile_row_num`, `tile_col_num`, and `dir_up`/`dir_down`/`dir_left`/`dir_right`; no new globals.
- Local state encoding: IDLE, CHECK, MOVE, ARRIVE.
- Sub-module `ghost_wall_lookup`: registered bit select of `tilemap_walls` at the target col/row, plus a boundary-violation flag.

## Test plan
- Reset, then `req` (600,340), walls clear, `STEP_PX`=4:
  - `blocked` = 0; `direction` = `dir_down`.
  - `pix_y` steps 324, 328, …, 340 on 5 ticks.
  - `arrive` fires with `y` = 340.
- Wall bit set at row 17, col 30, then `req` (600,340): `blocked` pulse in N+2; `x`/`y`/`pix` stay at 600/320.
- `req` (620,340), a diagonal move: rejected with `blocked`.
- From (600,320), `req` (600,320), a zero delta: rejected with `blocked`.
- From (0,0), `req` (-20 wrap, 0), which wraps to x = 1004: boundary reject with `blocked`.
- Reset asserted after 2 ticks of a move: `pix_y` returns to 320 at once; state is IDLE with `req_ready` = 1. A further `req_valid` pulse raised during MOVE is never accepted.
